// File: rtl/awb_gain_calc_pkg.sv
// Shared types and constants for the gray-world auto-white-balance block.
//   state_e    : gain-computation FSM states
//   COE_GAIN_W : significant width of one gain (the multiplier uses 13 LSBs)
//   COE_UNITY  : unity gain for the default Q3.10 format
//   CH_R/G/B   : channel slot indices on the pixel and coefficient buses
package awb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIV_R  = 2'd1,
    DIV_B  = 2'd2,
    UPDATE = 2'd3
  } state_e;

  localparam int unsigned COE_GAIN_W = 13;
  localparam logic [COE_GAIN_W-1:0] COE_UNITY = 13'h400;

  localparam int unsigned CH_R = 0;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 2;

endpackage

// File: rtl/awb_gain_calc_if.sv
// Pixel-tap and coefficient bus of the AWB gain generator.
//   di_i      : {B,G,R} pixel, PIXEL_WIDTH bits per component
//   de_i      : pixel valid
//   hs_i      : line sync (carried for bus uniformity)
//   vs_i      : frame sync, active-high
//   en_i      : 1 = apply computed gains, 0 = unity gains
//   coe_o     : {B,G,R} gains, COE_WIDTH bits per slot
//   coe_vld_o : one-cycle pulse when coe_o changes
//   busy_o    : gain computation in progress
// master = pixel source / gain consumer side, slave = awb_gain_calc.
interface awb_gain_calc_if #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned COE_WIDTH   = 16
);
  logic [PIXEL_WIDTH*3-1:0] di_i;
  logic                     de_i;
  logic                     hs_i;
  logic                     vs_i;
  logic                     en_i;
  logic [COE_WIDTH*3-1:0]   coe_o;
  logic                     coe_vld_o;
  logic                     busy_o;

  modport master (
    output di_i, de_i, hs_i, vs_i, en_i,
    input  coe_o, coe_vld_o, busy_o
  );

  modport slave (
    input  di_i, de_i, hs_i, vs_i, en_i,
    output coe_o, coe_vld_o, busy_o
  );
endinterface

// File: rtl/awb_gain_calc_div_seq.sv
// awb_div_seq: sequential restoring divider, one quotient bit per clock.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load dividend/divisor and begin (accepted at any time)
//   dividend  : DVD_W-bit unsigned dividend
//   divisor   : DVS_W-bit unsigned divisor
//   done      : one-cycle flag, quotient valid
//   quotient  : DVD_W-bit quotient, held until the next start
// A zero divisor skips the iterations: quotient becomes ZERO_ZERO_Q when the
// dividend is also zero, otherwise ZERO_Q, and done follows one cycle later.
module awb_div_seq
  import awb_pkg::*;
#(
  parameter int unsigned           DVD_W       = 42,
  parameter int unsigned           DVS_W       = 32,
  parameter logic [DVD_W-1:0]      ZERO_ZERO_Q = '0,
  parameter logic [DVD_W-1:0]      ZERO_Q      = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] dvd_q, dvd_d;   // remaining dividend bits, quotient shifts in at LSB
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [DVS_W:0]   shifted;
  logic [DVS_W-1:0] diff;
  logic             ge;

  always_comb begin
    shifted = {rem_q, dvd_q[DVD_W-1]};
    ge      = (shifted >= {1'b0, dvs_q});
    // True difference is below the divisor when ge, so modular subtraction suffices.
    diff    = shifted[DVS_W-1:0] - dvs_q;

    dvd_d = dvd_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    run_d = run_q;

    if (start) begin
      dvs_d = divisor;
      rem_d = '0;
      run_d = 1'b1;
      if (divisor == '0) begin
        cnt_d = '0;
        dvd_d = (dividend == '0) ? ZERO_ZERO_Q : ZERO_Q;
      end else begin
        cnt_d = CNT_W'(DVD_W);
        dvd_d = dividend;
      end
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (ge) begin
          rem_d = diff;
          dvd_d = {dvd_q[DVD_W-2:0], 1'b1};
        end else begin
          rem_d = shifted[DVS_W-1:0];
          dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done     = run_q && (cnt_q == '0);
  assign quotient = dvd_q;

endmodule

// File: rtl/awb_gain_calc.sv
// awb_gain_calc: gray-world auto-white-balance gain generator.
// Observes the RGB stream, accumulates per-channel sums over a frame and, at
// each vs rising edge, computes R and B gains (G/R, G/B in Q3.10) that are
// applied to coe_o once per frame. G gain is fixed at unity.
//   clk : pixel clock
//   rst : asynchronous reset, active-low
//   bus : awb_gain_calc_if.slave (di_i, de_i, hs_i, vs_i, en_i -> coe_o,
//         coe_vld_o, busy_o)
// Build option: define AWB_GAIN_IIR_EN to low-pass the gains across frames
// (coe = old + ((q - old) >>> IIR_SHIFT), clamped to [0, COE_MAX]).
module awb_gain_calc
  import awb_pkg::*;
#(
  parameter int unsigned            PIXEL_WIDTH        = 8,
  parameter int unsigned            COE_WIDTH          = 16,
  parameter int unsigned            COE_FRACTION_WIDTH = 10,
  parameter int unsigned            SUM_WIDTH          = 32,
  parameter logic [COE_GAIN_W-1:0]  COE_MAX            = 13'h1FFF,
  parameter int unsigned            IIR_SHIFT          = 2
) (
  input logic            clk,
  input logic            rst,
  awb_gain_calc_if.slave bus
);

  localparam int unsigned GW    = COE_GAIN_W;
  localparam int unsigned DVD_W = SUM_WIDTH + COE_FRACTION_WIDTH;
  localparam logic [GW-1:0] UNITY = GW'(1 << COE_FRACTION_WIDTH);

  state_e state_q, state_d;

  logic                      vs_q, vs_d;
  logic [2:0][SUM_WIDTH-1:0] sum_q, sum_d;
  logic [SUM_WIDTH-1:0]      snap_g_q, snap_g_d;
  logic [SUM_WIDTH-1:0]      snap_b_q, snap_b_d;
  logic [GW-1:0]             gain_r_q, gain_r_d;
  logic [GW-1:0]             gain_b_q, gain_b_d;
  logic [GW-1:0]             coe_r_q, coe_r_d;
  logic [GW-1:0]             coe_b_q, coe_b_d;
  logic                      coe_vld_q, coe_vld_d;

  logic                      edge_det;
  logic                      div_start;
  logic                      div_done;
  logic [DVD_W-1:0]          div_dividend;
  logic [SUM_WIDTH-1:0]      div_divisor;
  logic [DVD_W-1:0]          div_quotient;

  logic                      unused_hs;
  assign unused_hs = bus.hs_i;

  function automatic logic [SUM_WIDTH-1:0] sat_add(input logic [SUM_WIDTH-1:0]   a,
                                                   input logic [PIXEL_WIDTH-1:0] b);
    logic [SUM_WIDTH:0] s;
    s = {1'b0, a} + (SUM_WIDTH + 1)'(b);
    return s[SUM_WIDTH] ? '1 : s[SUM_WIDTH-1:0];
  endfunction

  function automatic logic [GW-1:0] clamp_q(input logic [DVD_W-1:0] q);
    return (q > DVD_W'(COE_MAX)) ? COE_MAX : q[GW-1:0];
  endfunction

`ifdef AWB_GAIN_IIR_EN
  function automatic logic [GW-1:0] blend(input logic [GW-1:0] old_g,
                                          input logic [GW-1:0] new_g);
    logic signed [GW+1:0] diff;
    logic signed [GW+1:0] acc;
    diff = $signed({2'b00, new_g}) - $signed({2'b00, old_g});
    acc  = $signed({2'b00, old_g}) + (diff >>> IIR_SHIFT);
    if (acc < 0)                              return '0;
    else if (acc > $signed({2'b00, COE_MAX})) return COE_MAX;
    else                                      return acc[GW-1:0];
  endfunction
`else
  localparam int unsigned unused_iir_shift = IIR_SHIFT;
`endif

  assign edge_det = bus.vs_i & ~vs_q;

  awb_div_seq #(
    .DVD_W       (DVD_W),
    .DVS_W       (SUM_WIDTH),
    .ZERO_ZERO_Q (DVD_W'(UNITY)),
    .ZERO_Q      (DVD_W'(COE_MAX))
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (edge_det) state_d = DIV_R;
      DIV_R:   if (div_done) state_d = DIV_B;
      DIV_B:   if (div_done) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs. The R divide is launched straight from the live sums on the
  // edge (the divider latches them); the B divide chains off the R done using
  // the snapshot, so the two divides run back to back.
  always_comb begin
    bus.busy_o   = (state_q != IDLE);
    div_start    = 1'b0;
    div_dividend = {sum_q[CH_G], {COE_FRACTION_WIDTH{1'b0}}};
    div_divisor  = sum_q[CH_R];
    unique case (state_q)
      IDLE:  div_start = edge_det;
      DIV_R: begin
        div_start    = div_done;
        div_dividend = {snap_g_q, {COE_FRACTION_WIDTH{1'b0}}};
        div_divisor  = snap_b_q;
      end
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    vs_d      = bus.vs_i;
    sum_d     = sum_q;
    snap_g_d  = snap_g_q;
    snap_b_d  = snap_b_q;
    gain_r_d  = gain_r_q;
    gain_b_d  = gain_b_q;
    coe_r_d   = coe_r_q;
    coe_b_d   = coe_b_q;
    coe_vld_d = (state_q == UPDATE);

    // The edge clears all sums; a pixel in the edge cycle opens the new frame.
    for (int unsigned ch = 0; ch < 3; ch++) begin
      if (edge_det)
        sum_d[ch] = bus.de_i ? SUM_WIDTH'(bus.di_i[ch*PIXEL_WIDTH +: PIXEL_WIDTH]) : '0;
      else if (bus.de_i)
        sum_d[ch] = sat_add(sum_q[ch], bus.di_i[ch*PIXEL_WIDTH +: PIXEL_WIDTH]);
    end

    if (state_q == IDLE && edge_det) begin
      snap_g_d = sum_q[CH_G];
      snap_b_d = sum_q[CH_B];
    end

    if (state_q == DIV_R && div_done) gain_r_d = clamp_q(div_quotient);
    if (state_q == DIV_B && div_done) gain_b_d = clamp_q(div_quotient);

    if (state_q == UPDATE) begin
      if (!bus.en_i) begin
        coe_r_d = UNITY;
        coe_b_d = UNITY;
      end else begin
`ifdef AWB_GAIN_IIR_EN
        coe_r_d = blend(coe_r_q, gain_r_q);
        coe_b_d = blend(coe_b_q, gain_b_q);
`else
        coe_r_d = gain_r_q;
        coe_b_d = gain_b_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_q      <= 1'b0;
      sum_q     <= '0;
      snap_g_q  <= '0;
      snap_b_q  <= '0;
      gain_r_q  <= UNITY;
      gain_b_q  <= UNITY;
      coe_r_q   <= UNITY;
      coe_b_q   <= UNITY;
      coe_vld_q <= 1'b0;
    end else begin
      vs_q      <= vs_d;
      sum_q     <= sum_d;
      snap_g_q  <= snap_g_d;
      snap_b_q  <= snap_b_d;
      gain_r_q  <= gain_r_d;
      gain_b_q  <= gain_b_d;
      coe_r_q   <= coe_r_d;
      coe_b_q   <= coe_b_d;
      coe_vld_q <= coe_vld_d;
    end
  end

  always_comb begin
    bus.coe_o = '0;
    bus.coe_o[CH_R*COE_WIDTH +: GW] = coe_r_q;
    bus.coe_o[CH_G*COE_WIDTH +: GW] = UNITY;
    bus.coe_o[CH_B*COE_WIDTH +: GW] = coe_b_q;
  end

  assign bus.coe_vld_o = coe_vld_q;

endmodule

// File: tb/tb_awb_gain_calc.sv
// Directed self-checking bench for awb_gain_calc (default Q3.10, N = 42).
module tb_awb_gain_calc;

  localparam int LAT = 2 * 42 + 3;

`ifdef AWB_GAIN_IIR_EN
  localparam logic [15:0] T1_R  = 16'h0500, T1_B  = 16'h0700;
  localparam logic [15:0] T3_R  = 16'h0AFF;
  localparam logic [15:0] T4C_R = 16'h0440, T4C_B = 16'h0740;
`else
  localparam logic [15:0] T1_R  = 16'h0800, T1_B  = 16'h1000;
  localparam logic [15:0] T3_R  = 16'h1FFF;
  localparam logic [15:0] T4C_R = 16'h0200, T4C_B = 16'h0800;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  awb_gain_calc_if #(.PIXEL_WIDTH(8), .COE_WIDTH(16)) bus ();

  awb_gain_calc #(
    .PIXEL_WIDTH        (8),
    .COE_WIDTH          (16),
    .COE_FRACTION_WIDTH (10),
    .SUM_WIDTH          (32),
    .COE_MAX            (13'h1FFF),
    .IIR_SHIFT          (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pk(input logic [15:0] r, input logic [15:0] g,
                                     input logic [15:0] b);
    return {b, g, r};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    bus.di_i = '0; bus.de_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.en_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_pixels(input int n, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      bus.de_i = 1'b1;
      bus.di_i = {b, g, r};
      @(negedge clk);
    end
    bus.de_i = 1'b0;
    bus.di_i = '0;
  endtask

  task automatic pulse_vs();
    bus.vs_i = 1'b1;
    @(negedge clk);
    bus.vs_i = 1'b0;
  endtask

  // cyc = clocks from the edge-sampling clock to the first visible coe_vld_o
  task automatic wait_vld(input int limit, output int cyc, output bit got);
    cyc = 0;
    while (!bus.coe_vld_o && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    got = bus.coe_vld_o;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.coe_o !== pk(16'h400, 16'h400, 16'h400))
      $display("FAIL reset_coe: got %h expected %h", bus.coe_o, pk(16'h400, 16'h400, 16'h400));
    else passed++;
    checks++;
    if (bus.coe_vld_o !== 1'b0) $display("FAIL reset_vld: got %b expected 0", bus.coe_vld_o);
    else passed++;
    checks++;
    if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
    else passed++;
  endtask

  task automatic test_main(input bit en);
    int          cyc;
    bit          got;
    logic [47:0] exp_coe;
    exp_coe = en ? pk(T1_R, 16'h400, T1_B) : pk(16'h400, 16'h400, 16'h400);
    do_reset();
    bus.en_i = en;
    send_pixels(4, 8'd64, 8'd128, 8'd32);
    pulse_vs();
    checks++;
    if (bus.busy_o !== 1'b1) $display("FAIL main_busy_start: got %b expected 1", bus.busy_o);
    else passed++;
    wait_vld(200, cyc, got);
    checks++;
    if (!got || cyc != LAT)
      $display("FAIL main_latency en=%0d: got vld=%0d after %0d clocks expected %0d", en, got, cyc, LAT);
    else passed++;
    checks++;
    if (bus.coe_o !== exp_coe)
      $display("FAIL main_coe en=%0d: got %h expected %h", en, bus.coe_o, exp_coe);
    else passed++;
    checks++;
    if (bus.busy_o !== 1'b0) $display("FAIL main_busy_end: got %b expected 0", bus.busy_o);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.coe_vld_o !== 1'b0) $display("FAIL main_vld_width: got %b expected 0", bus.coe_vld_o);
    else passed++;
    bus.en_i = 1'b1;
  endtask

  task automatic test_zero_frame();
    int cyc;
    bit got;
    do_reset();
    pulse_vs();
    wait_vld(200, cyc, got);
    checks++;
    if (!got) $display("FAIL zero_vld: got no pulse within %0d clocks expected pulse", cyc);
    else passed++;
    checks++;
    if (bus.coe_o !== pk(16'h400, 16'h400, 16'h400))
      $display("FAIL zero_coe: got %h expected %h", bus.coe_o, pk(16'h400, 16'h400, 16'h400));
    else passed++;
  endtask

  task automatic test_clamp();
    int cyc;
    bit got;
    do_reset();
    send_pixels(1, 8'd0, 8'd100, 8'd100);
    pulse_vs();
    wait_vld(200, cyc, got);
    checks++;
    if (!got || bus.coe_o !== pk(T3_R, 16'h400, 16'h400))
      $display("FAIL clamp_coe: got vld=%0d coe=%h expected %h", got, bus.coe_o, pk(T3_R, 16'h400, 16'h400));
    else passed++;
  endtask

  task automatic test_back_to_back();
    int          nvld;
    int          cyc;
    bit          got;
    logic [47:0] cap;
    do_reset();
    send_pixels(4, 8'd64, 8'd128, 8'd32);
    pulse_vs();                               // edge 1
    send_pixels(3, 8'd255, 8'd1, 8'd7);       // dropped by edge 2
    repeat (6) @(negedge clk);
    bus.vs_i = 1'b1; bus.de_i = 1'b1; bus.di_i = {8'd2, 8'd10, 8'd30};  // edge 2 + first pixel
    @(negedge clk);
    bus.vs_i = 1'b0; bus.di_i = {8'd8, 8'd10, 8'd10};
    @(negedge clk);
    bus.de_i = 1'b0; bus.di_i = '0;
    nvld = 0;
    cap  = '0;
    for (int i = 0; i < 200; i++) begin
      if (bus.coe_vld_o) begin
        nvld++;
        cap = bus.coe_o;
      end
      @(negedge clk);
    end
    checks++;
    if (nvld != 1) $display("FAIL b2b_vld_count: got %0d expected 1", nvld);
    else passed++;
    checks++;
    if (cap !== pk(T1_R, 16'h400, T1_B))
      $display("FAIL b2b_first_coe: got %h expected %h", cap, pk(T1_R, 16'h400, T1_B));
    else passed++;
    pulse_vs();                               // edge 3 closes frame C
    wait_vld(200, cyc, got);
    checks++;
    if (!got || bus.coe_o !== pk(T4C_R, 16'h400, T4C_B))
      $display("FAIL b2b_second_coe: got vld=%0d coe=%h expected %h", got, bus.coe_o, pk(T4C_R, 16'h400, T4C_B));
    else passed++;
  endtask

  task automatic test_mid_reset();
    int nvld;
    do_reset();
    send_pixels(4, 8'd64, 8'd128, 8'd32);
    pulse_vs();
    repeat (60) @(negedge clk);               // inside the B divide
    checks++;
    if (bus.busy_o !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", bus.busy_o);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.coe_o !== pk(16'h400, 16'h400, 16'h400) || bus.busy_o !== 1'b0 || bus.coe_vld_o !== 1'b0)
      $display("FAIL midrst_state: got coe=%h busy=%b vld=%b expected %h 0 0",
               bus.coe_o, bus.busy_o, bus.coe_vld_o, pk(16'h400, 16'h400, 16'h400));
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    nvld = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.coe_vld_o) nvld++;
    end
    checks++;
    if (nvld != 0) $display("FAIL midrst_no_vld: got %0d pulses expected 0", nvld);
    else passed++;
  endtask

`ifdef AWB_GAIN_IIR_EN
  task automatic test_iir();
    logic [15:0] exp_r [3];
    int          cyc;
    bit          got;
    exp_r[0] = 16'h0500; exp_r[1] = 16'h05C0; exp_r[2] = 16'h0650;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      send_pixels(4, 8'd64, 8'd128, 8'd32);
      pulse_vs();
      wait_vld(200, cyc, got);
      checks++;
      if (!got || bus.coe_o[15:0] !== exp_r[f])
        $display("FAIL iir_r frame %0d: got vld=%0d r=%h expected %h", f, got, bus.coe_o[15:0], exp_r[f]);
      else passed++;
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b0;
    bus.di_i = '0; bus.de_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.en_i = 1'b1;
    test_reset();
    test_main(1'b1);
    test_zero_frame();
    test_clamp();
    test_back_to_back();
    test_mid_reset();
    test_main(1'b1);
    test_main(1'b0);
`ifdef AWB_GAIN_IIR_EN
    test_iir();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
